// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares the single-transaction host interface of sdram_controller between
// two clients in the same clock domain:
//   port A : VGA display fetch, read-only, high priority
//   port B : general read/write client (e.g. pixel writer)
//
// Exactly one SDRAM command is in flight at a time. The granted request is
// latched, its enable is held until the controller reports busy, and the
// read data or write completion is returned to the port that owns the
// transaction. A grant-streak counter stops a continuously requesting port A
// from starving port B.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   a_valid_i, a_addr_i    port A read request (held until a_ready_o)
//   a_ready_o              one-cycle pulse: A request latched
//   a_rdata_o, a_rvalid_o  A read data, one-cycle valid pulse
//   b_valid_i, b_we_i,     port B request (held until b_ready_o),
//   b_addr_i, b_wdata_i    1 = write / 0 = read
//   b_ready_o              one-cycle pulse: B request latched
//   b_rdata_o, b_rvalid_o  B read data, one-cycle valid pulse
//   b_wdone_o              one-cycle pulse: B write retired
//   sd_rd_addr_o,          controller addresses, both from the latched address
//   sd_wr_addr_o
//   sd_wr_data_o           latched write data
//   sd_rd_enable_o,        controller command strobes (mutually exclusive)
//   sd_wr_enable_o
//   sd_rd_data_i,          controller read data and its one-cycle strobe
//   sd_rd_ready_i
//   sd_busy_i              controller read/write in progress
//   arb_idle_o             high while the arbiter is in IDLE
// -----------------------------------------------------------------------------
module sdram_arbiter #(
   parameter int unsigned A_MAX_STREAK = 4,   // legal range 1..15
   parameter int unsigned ADDR_W       = 24
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   // port A (read-only, high priority)
   input  logic              a_valid_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   output logic              a_ready_o,
   output logic [15:0]       a_rdata_o,
   output logic              a_rvalid_o,
   // port B (read/write)
   input  logic              b_valid_i,
   input  logic              b_we_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [15:0]       b_wdata_i,
   output logic              b_ready_o,
   output logic [15:0]       b_rdata_o,
   output logic              b_rvalid_o,
   output logic              b_wdone_o,
   // sdram_controller host interface
   output logic [ADDR_W-1:0] sd_rd_addr_o,
   output logic [ADDR_W-1:0] sd_wr_addr_o,
   output logic [15:0]       sd_wr_data_o,
   output logic              sd_rd_enable_o,
   output logic              sd_wr_enable_o,
   input  logic [15:0]       sd_rd_data_i,
   input  logic              sd_rd_ready_i,
   input  logic              sd_busy_i,
   // status
   output logic              arb_idle_o
);

   localparam int unsigned DATA_W     = 16;
   localparam logic [3:0]  STREAK_MAX = 4'(A_MAX_STREAK);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t              state_q;
   logic                own_b_q;     // 0 = port A owns the transaction, 1 = port B
   logic                op_wr_q;     // 0 = read, 1 = write
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   a_rdata_q;
   logic [DATA_W-1:0]   b_rdata_q;
   logic [3:0]          streak_q;
   logic                a_ready_q;
   logic                b_ready_q;
   logic                a_rvalid_q;
   logic                b_rvalid_q;
   logic                b_wdone_q;
   logic                rd_en_q;
   logic                wr_en_q;
   logic                idle_q;

   logic                grant_a_d;
   logic                grant_b_d;
   logic [3:0]          streak_d;

   // Saturating increment of the A grant streak.
   function automatic logic [3:0] streak_inc(input logic [3:0] s);
      if (s >= STREAK_MAX) begin
         return STREAK_MAX;
      end
      return s + 4'd1;
   endfunction

   // Grant decision; only acted on in IDLE. A wins a tie unless it has already
   // taken STREAK_MAX grants in a row while B was waiting.
   always_comb begin
      grant_a_d = 1'b0;
      grant_b_d = 1'b0;
      if (a_valid_i && !(b_valid_i && (streak_q == STREAK_MAX))) begin
         grant_a_d = 1'b1;
      end else if (b_valid_i) begin
         grant_b_d = 1'b1;
      end
   end

   // The streak only counts A grants that actually made B wait; any IDLE cycle
   // without a B request, or a B grant, starts the count over.
   always_comb begin
      streak_d = streak_q;
      if (state_q == S_IDLE) begin
         if (!b_valid_i || grant_b_d) begin
            streak_d = 4'd0;
         end else if (grant_a_d) begin
            streak_d = streak_inc(streak_q);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         own_b_q    <= 1'b0;
         op_wr_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
         streak_q   <= 4'd0;
         a_ready_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         b_wdone_q  <= 1'b0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         idle_q     <= 1'b1;
      end else begin
         // handshake and completion outputs are single-cycle pulses
         a_ready_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         b_wdone_q  <= 1'b0;
         streak_q   <= streak_d;

         case (state_q)
            S_IDLE: begin
               if (grant_a_d || grant_b_d) begin
                  own_b_q   <= grant_b_d;
                  op_wr_q   <= grant_b_d & b_we_i;
                  addr_q    <= grant_b_d ? b_addr_i : a_addr_i;
                  if (grant_b_d) begin
                     wdata_q <= b_wdata_i;
                  end
                  a_ready_q <= grant_a_d;
                  b_ready_q <= grant_b_d;
                  rd_en_q   <= ~(grant_b_d & b_we_i);
                  wr_en_q   <= grant_b_d & b_we_i;
                  idle_q    <= 1'b0;
                  state_q   <= S_ISSUE;
               end
            end

            // The controller silently ignores the enable during init and
            // refresh (busy stays low), so hold it here for as long as needed.
            S_ISSUE: begin
               if (sd_busy_i) begin
                  rd_en_q <= 1'b0;
                  wr_en_q <= 1'b0;
                  state_q <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (op_wr_q) begin
                  if (!sd_busy_i) begin
                     b_wdone_q <= 1'b1;
                     idle_q    <= 1'b1;
                     state_q   <= S_IDLE;
                  end
               end else if (sd_rd_ready_i) begin
                  if (own_b_q) begin
                     b_rdata_q  <= sd_rd_data_i;
                     b_rvalid_q <= 1'b1;
                  end else begin
                     a_rdata_q  <= sd_rd_data_i;
                     a_rvalid_q <= 1'b1;
                  end
                  idle_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end

            default: begin
               rd_en_q <= 1'b0;
               wr_en_q <= 1'b0;
               idle_q  <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // All outputs come straight from registers.
   assign a_ready_o      = a_ready_q;
   assign a_rdata_o      = a_rdata_q;
   assign a_rvalid_o     = a_rvalid_q;
   assign b_ready_o      = b_ready_q;
   assign b_rdata_o      = b_rdata_q;
   assign b_rvalid_o     = b_rvalid_q;
   assign b_wdone_o      = b_wdone_q;
   assign sd_rd_addr_o   = addr_q;
   assign sd_wr_addr_o   = addr_q;
   assign sd_wr_data_o   = wdata_q;
   assign sd_rd_enable_o = rd_en_q;
   assign sd_wr_enable_o = wr_en_q;
   assign arb_idle_o     = idle_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with an expected-response scoreboard and a
// small behavioural model of sdram_controller.
module tb_sdram_arbiter;

   localparam int ADDR_W = 24;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic              a_ready;
   logic [15:0]       a_rdata;
   logic              a_rvalid;
   logic              b_valid;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [15:0]       b_wdata;
   logic              b_ready;
   logic [15:0]       b_rdata;
   logic              b_rvalid;
   logic              b_wdone;
   logic [ADDR_W-1:0] sd_rd_addr;
   logic [ADDR_W-1:0] sd_wr_addr;
   logic [15:0]       sd_wr_data;
   logic              sd_rd_enable;
   logic              sd_wr_enable;
   logic [15:0]       sd_rd_data;
   logic              sd_rd_ready;
   logic              sd_busy;
   logic              arb_idle;

   always #5 clk = ~clk;

   sdram_arbiter #(.A_MAX_STREAK(4), .ADDR_W(ADDR_W)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .a_valid_i      (a_valid),
      .a_addr_i       (a_addr),
      .a_ready_o      (a_ready),
      .a_rdata_o      (a_rdata),
      .a_rvalid_o     (a_rvalid),
      .b_valid_i      (b_valid),
      .b_we_i         (b_we),
      .b_addr_i       (b_addr),
      .b_wdata_i      (b_wdata),
      .b_ready_o      (b_ready),
      .b_rdata_o      (b_rdata),
      .b_rvalid_o     (b_rvalid),
      .b_wdone_o      (b_wdone),
      .sd_rd_addr_o   (sd_rd_addr),
      .sd_wr_addr_o   (sd_wr_addr),
      .sd_wr_data_o   (sd_wr_data),
      .sd_rd_enable_o (sd_rd_enable),
      .sd_wr_enable_o (sd_wr_enable),
      .sd_rd_data_i   (sd_rd_data),
      .sd_rd_ready_i  (sd_rd_ready),
      .sd_busy_i      (sd_busy),
      .arb_idle_o     (arb_idle)
   );

   typedef struct packed {
      logic        port_b;
      logic        we;
      logic [23:0] addr;
      logic [15:0] data;
   } txn_t;

   typedef struct packed {
      logic        we;
      logic [23:0] addr;
      logic [15:0] data;
   } breq_t;

   txn_t        grant_q[$];   // expected grants, in order
   txn_t        cmpl_q[$];    // expected completions, in order
   logic [23:0] a_drv_q[$];
   breq_t       b_drv_q[$];

   int nvec = 0;
   int nerr = 0;

   // ---------------- controller model ----------------
   logic        blocked;      // init / refresh: enables ignored, busy low
   logic [15:0] mem [256];
   logic        m_busy;
   logic [2:0]  m_cnt;
   logic        m_we;
   logic [23:0] m_addr;
   logic [15:0] m_wdata;

   function automatic logic [15:0] pat(input logic [23:0] a);
      return {a[7:0], a[7:0] ^ 8'hC3};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sd_busy     <= 1'b0;
         sd_rd_ready <= 1'b0;
         sd_rd_data  <= 16'h0;
         m_busy      <= 1'b0;
         m_cnt       <= 3'd0;
         m_we        <= 1'b0;
         m_addr      <= 24'h0;
         m_wdata     <= 16'h0;
         for (int i = 0; i < 256; i++) mem[i] <= pat(24'(i));
         mem[8'h45] <= 16'hBEEF;
      end else begin
         sd_rd_ready <= 1'b0;
         if (!m_busy) begin
            if (!blocked && (sd_rd_enable || sd_wr_enable)) begin
               m_busy  <= 1'b1;
               sd_busy <= 1'b1;
               m_we    <= sd_wr_enable;
               m_addr  <= sd_wr_enable ? sd_wr_addr : sd_rd_addr;
               m_wdata <= sd_wr_data;
               m_cnt   <= 3'd3;
            end
         end else if (m_cnt != 3'd0) begin
            m_cnt <= m_cnt - 3'd1;
         end else begin
            m_busy  <= 1'b0;
            sd_busy <= 1'b0;
            if (m_we) begin
               mem[m_addr[7:0]] <= m_wdata;
            end else begin
               sd_rd_ready <= 1'b1;
               sd_rd_data  <= mem[m_addr[7:0]];
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic exp_txn(input logic pb, input logic we, input logic [23:0] ad,
                          input logic [15:0] d);
      grant_q.push_back({pb, we, ad, d});
      cmpl_q.push_back({pb, we, ad, d});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_a_ready"},  32'(a_ready),      32'h0);
      chk({tag, "_a_rvalid"}, 32'(a_rvalid),     32'h0);
      chk({tag, "_a_rdata"},  32'(a_rdata),      32'h0);
      chk({tag, "_b_ready"},  32'(b_ready),      32'h0);
      chk({tag, "_b_rvalid"}, 32'(b_rvalid),     32'h0);
      chk({tag, "_b_rdata"},  32'(b_rdata),      32'h0);
      chk({tag, "_b_wdone"},  32'(b_wdone),      32'h0);
      chk({tag, "_rd_addr"},  32'(sd_rd_addr),   32'h0);
      chk({tag, "_wr_addr"},  32'(sd_wr_addr),   32'h0);
      chk({tag, "_wr_data"},  32'(sd_wr_data),   32'h0);
      chk({tag, "_enables"},  32'({sd_rd_enable, sd_wr_enable}), 32'h0);
      chk({tag, "_idle"},     32'(arb_idle),     32'h1);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((grant_q.size() != 0 || cmpl_q.size() != 0 || a_drv_q.size() != 0 ||
              b_drv_q.size() != 0 || !arb_idle) && n < 500) begin
         tick();
         n++;
      end
      chk({tag, "_drain_timeout"}, 32'(n < 500), 32'h1);
      if (n >= 500) begin
         grant_q.delete();
         cmpl_q.delete();
         a_drv_q.delete();
         b_drv_q.delete();
      end
      repeat (2) tick();
   endtask

   // ---------------- port drivers ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         a_valid = 1'b0;
         a_addr  = '0;
         b_valid = 1'b0;
         b_we    = 1'b0;
         b_addr  = '0;
         b_wdata = '0;
      end else begin
         if (a_ready && a_drv_q.size() != 0) void'(a_drv_q.pop_front());
         if (b_ready && b_drv_q.size() != 0) void'(b_drv_q.pop_front());
         a_valid = (a_drv_q.size() != 0);
         a_addr  = a_valid ? a_drv_q[0] : '0;
         b_valid = (b_drv_q.size() != 0);
         b_we    = b_valid ? b_drv_q[0].we   : 1'b0;
         b_addr  = b_valid ? b_drv_q[0].addr : '0;
         b_wdata = b_valid ? b_drv_q[0].data : '0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   txn_t        g;
   txn_t        c;
   logic        prev_rd_ready, prev_busy, prev_rd_en, prev_wr_en;
   logic [23:0] prev_rd_addr, prev_wr_addr;
   logic [15:0] prev_wr_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_rd_ready = 1'b0;
         prev_busy     = 1'b0;
         prev_rd_en    = 1'b0;
         prev_wr_en    = 1'b0;
         prev_rd_addr  = '0;
         prev_wr_addr  = '0;
         prev_wr_data  = '0;
      end else begin
         if (sd_rd_enable || sd_wr_enable)
            chk("enable_exclusive", 32'(sd_rd_enable & sd_wr_enable), 32'h0);
         if (a_ready || b_ready)
            chk("ready_exclusive", 32'(a_ready & b_ready), 32'h0);

         if (a_ready) begin
            if (grant_q.size() == 0) chk("a_ready_unexpected", 32'h1, 32'h0);
            else begin
               g = grant_q.pop_front();
               chk("a_grant_port", 32'(g.port_b), 32'h0);
               chk("a_grant_addr", 32'(sd_rd_addr), 32'(g.addr));
               chk("a_grant_enables", 32'({sd_rd_enable, sd_wr_enable}), 32'h2);
            end
         end
         if (b_ready) begin
            if (grant_q.size() == 0) chk("b_ready_unexpected", 32'h1, 32'h0);
            else begin
               g = grant_q.pop_front();
               chk("b_grant_port", 32'(g.port_b), 32'h1);
               if (g.we) begin
                  chk("b_grant_wr_addr", 32'(sd_wr_addr), 32'(g.addr));
                  chk("b_grant_wr_data", 32'(sd_wr_data), 32'(g.data));
                  chk("b_grant_enables", 32'({sd_rd_enable, sd_wr_enable}), 32'h1);
               end else begin
                  chk("b_grant_rd_addr", 32'(sd_rd_addr), 32'(g.addr));
                  chk("b_grant_enables", 32'({sd_rd_enable, sd_wr_enable}), 32'h2);
               end
            end
         end

         if (a_rvalid) begin
            if (cmpl_q.size() == 0) chk("a_rvalid_unexpected", 32'h1, 32'h0);
            else begin
               c = cmpl_q.pop_front();
               chk("a_rvalid_owner", 32'({c.port_b, c.we}), 32'h0);
               chk("a_rdata", 32'(a_rdata), 32'(c.data));
               chk("a_rvalid_latency", 32'(prev_rd_ready), 32'h1);
            end
         end
         if (b_rvalid) begin
            if (cmpl_q.size() == 0) chk("b_rvalid_unexpected", 32'h1, 32'h0);
            else begin
               c = cmpl_q.pop_front();
               chk("b_rvalid_owner", 32'({c.port_b, c.we}), 32'h2);
               chk("b_rdata", 32'(b_rdata), 32'(c.data));
               chk("b_rvalid_latency", 32'(prev_rd_ready), 32'h1);
            end
         end
         if (b_wdone) begin
            if (cmpl_q.size() == 0) chk("b_wdone_unexpected", 32'h1, 32'h0);
            else begin
               c = cmpl_q.pop_front();
               chk("b_wdone_owner", 32'({c.port_b, c.we}), 32'h3);
               chk("b_wdone_latency", 32'(prev_busy), 32'h0);
            end
         end

         // enable must stay steady until busy is seen, then drop
         if (prev_rd_en && !sd_rd_enable) chk("rd_en_drop_after_busy", 32'(prev_busy), 32'h1);
         if (prev_wr_en && !sd_wr_enable) chk("wr_en_drop_after_busy", 32'(prev_busy), 32'h1);
         if (prev_rd_en && sd_rd_enable) chk("rd_addr_stable", 32'(sd_rd_addr), 32'(prev_rd_addr));
         if (prev_wr_en && sd_wr_enable) begin
            chk("wr_addr_stable", 32'(sd_wr_addr), 32'(prev_wr_addr));
            chk("wr_data_stable", 32'(sd_wr_data), 32'(prev_wr_data));
         end

         prev_rd_ready = sd_rd_ready;
         prev_busy     = sd_busy;
         prev_rd_en    = sd_rd_enable;
         prev_wr_en    = sd_wr_enable;
         prev_rd_addr  = sd_rd_addr;
         prev_wr_addr  = sd_wr_addr;
         prev_wr_data  = sd_wr_data;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst_n   = 1'b0;
      blocked = 1'b0;
      repeat (3) tick();
      check_reset_outputs("por");
      rst_n = 1'b1;

      // A read issued during controller init
      blocked = 1'b1;
      exp_txn(1'b0, 1'b0, 24'h012345, 16'hBEEF);
      a_drv_q.push_back(24'h012345);
      repeat (15) tick();
      chk("init_rd_en_held", 32'(sd_rd_enable), 32'h1);
      chk("init_rd_addr_held", 32'(sd_rd_addr), 32'h012345);
      blocked = 1'b0;
      wait_drain("t1_init_read");

      // simultaneous A and B read: A first, then B
      exp_txn(1'b0, 1'b0, 24'h000020, pat(24'h000020));
      exp_txn(1'b1, 1'b0, 24'h000021, pat(24'h000021));
      a_drv_q.push_back(24'h000020);
      b_drv_q.push_back({1'b0, 24'h000021, 16'h0});
      wait_drain("t2_tie");

      // A streaming, B waiting: AAAA B AAAA B A
      for (int i = 0; i < 4; i++) exp_txn(1'b0, 1'b0, 24'(32'h30 + i), pat(24'(32'h30 + i)));
      exp_txn(1'b1, 1'b0, 24'h000040, pat(24'h000040));
      for (int i = 4; i < 8; i++) exp_txn(1'b0, 1'b0, 24'(32'h30 + i), pat(24'(32'h30 + i)));
      exp_txn(1'b1, 1'b0, 24'h000041, pat(24'h000041));
      exp_txn(1'b0, 1'b0, 24'h000038, pat(24'h000038));
      for (int i = 0; i < 9; i++) a_drv_q.push_back(24'(32'h30 + i));
      b_drv_q.push_back({1'b0, 24'h000040, 16'h0});
      b_drv_q.push_back({1'b0, 24'h000041, 16'h0});
      wait_drain("t3_streak");

      // B write then read back
      exp_txn(1'b1, 1'b1, 24'h00FF00, 16'h5A5A);
      exp_txn(1'b1, 1'b0, 24'h00FF00, 16'h5A5A);
      b_drv_q.push_back({1'b1, 24'h00FF00, 16'h5A5A});
      b_drv_q.push_back({1'b0, 24'h00FF00, 16'h0});
      wait_drain("t4_wr_rd");

      // requests during a 20-cycle refresh window, then read the write back via A
      blocked = 1'b1;
      exp_txn(1'b0, 1'b0, 24'h000050, pat(24'h000050));
      exp_txn(1'b1, 1'b1, 24'h000051, 16'h1357);
      a_drv_q.push_back(24'h000050);
      b_drv_q.push_back({1'b1, 24'h000051, 16'h1357});
      repeat (20) tick();
      chk("refresh_rd_en_held", 32'(sd_rd_enable), 32'h1);
      chk("refresh_rd_addr_held", 32'(sd_rd_addr), 32'h000050);
      blocked = 1'b0;
      wait_drain("t5_refresh");
      exp_txn(1'b0, 1'b0, 24'h000051, 16'h1357);
      a_drv_q.push_back(24'h000051);
      wait_drain("t5_readback");

      // asynchronous reset while a read is pending in WAIT
      exp_txn(1'b0, 1'b0, 24'h0A0B0C, pat(24'h0A0B0C));
      a_drv_q.push_back(24'h0A0B0C);
      n = 0;
      while (!(sd_busy && !sd_rd_enable && !arb_idle) && n < 100) begin
         tick();
         n++;
      end
      chk("rst_reach_wait", 32'(n < 100), 32'h1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      grant_q.delete();
      cmpl_q.delete();
      a_drv_q.delete();
      b_drv_q.delete();
      repeat (3) tick();
      check_reset_outputs("rst_held");
      rst_n = 1'b1;
      tick();

      // fresh A read after reset
      exp_txn(1'b0, 1'b0, 24'h000077, pat(24'h000077));
      a_drv_q.push_back(24'h000077);
      wait_drain("t6_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter that shares the single-transaction host interface of `sdram_controller` between the VGA display fetch (port A, read-only, high priority) and a general read/write client (port B, e.g. pixel writer). It sits between the VGA system clients and `sdram_controller` in the same clock domain. It issues one SDRAM command at a time, holds the command until the controller accepts it, and returns read data or write completion to the owning port. It bounds port-B starvation with a grant-streak limit.

## Interface
- `A_MAX_STREAK`, default 4: max consecutive A grants while B is waiting; legal range 1..15.
- `ADDR_W`, default 24: host address width, {bank, row, col}.
- `clk`  in  1  system clock, same clock as `sdram_controller`
- `rst_n`  in  1  asynchronous active-low reset
- `a_valid`  in  1  port A read request; held until `a_ready`
- `a_addr`  in  ADDR_W  port A read address
- `a_ready`  out  1  one-cycle pulse: A request latched
- `a_rdata`  out  16  port A read data
- `a_rvalid`  out  1  one-cycle pulse: `a_rdata` valid
- `b_valid`  in  1  port B request; held until `b_ready`
- `b_we`  in  1  1 = write, 0 = read
- `b_addr`  in  ADDR_W  port B address
- `b_wdata`  in  16  port B write data
- `b_ready`  out  1  one-cycle pulse: B request latched
- `b_rdata`  out  16  port B read data
- `b_rvalid`  out  1  one-cycle pulse: `b_rdata` valid
- `b_wdone`  out  1  one-cycle pulse: B write retired
- `sd_rd_addr`, `sd_wr_addr`  out  ADDR_W  both driven from the latched address
- `sd_wr_data`  out  16  latched write data
- `sd_rd_enable`, `sd_wr_enable`  out  1  controller command strobes, never both high
- `sd_rd_data`  in  16  controller read data
- `sd_rd_ready`  in  1  controller read-data pulse
- `sd_busy`  in  1  controller busy (read/write in progress)
- `arb_idle`  out  1  high in IDLE

## Operation
- States: IDLE, ISSUE, WAIT. Owner register `own` (A/B), operation `op` (RD/WR), latched `addr_q` and `wdata_q`.
- IDLE, at clk edge:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant A unless `streak == A_MAX_STREAK`, in which case grant B.
  - On a grant: latch addr/op/wdata and the owner, pulse the owner's ready next cycle, set the matching `sd_*_enable`, and go to ISSUE.
- Streak counter, 4 bits:
  - +1 on each A grant made while `b_valid` is high.
  - Cleared on any B grant, and in any IDLE cycle with `b_valid` low.
  - Saturates at `A_MAX_STREAK`.
- ISSUE: hold the enable, address and data steady until `sd_busy` = 1. Then drop the enable and go to WAIT.
  - The controller ignores enables during init and refresh, where `sd_busy` stays 0. ISSUE therefore waits indefinitely; there is no timeout.
- WAIT:
  - RD: on `sd_rd_ready`, capture `sd_rd_data` into the owner's rdata register, pulse the owner's rvalid next cycle, and go to IDLE.
  - WR: on `sd_busy` = 0, pulse `b_wdone` next cycle and go to IDLE.
- Port data registers hold their last value until the next read for that port.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; streak, `own`, `addr_q`, `wdata_q`, both rdata registers cleared.
  - All outputs 0: enables, ready/rvalid/wdone pulses, addresses, data; `arb_idle` = 1.
  - An in-flight transaction is abandoned with no completion pulse. The controller shares `rst_n` and re-initialises.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Grant edge E0: ready pulse and enable are high in cycle E0+1.
  - Controller leaves IDLE at E0+1.
  - `sd_busy` rises at E0+2 at the earliest.
  - The enable drops the cycle after `sd_busy` is sampled high.
- The controller re-latches address and data while the enable is held. Both stay constant, so this is harmless.
- Read completion: rvalid is high exactly one cycle after the `sd_rd_ready` pulse.
- Write completion: `b_wdone` is high one cycle after `sd_busy` is first sampled low in WAIT.
- Back-to-back: the next grant can be made in the first IDLE cycle, i.e. the edge after the completion pulse is scheduled.
- The requester must deassert or update valid in the cycle ready is high. Valid is not resampled until IDLE.

## Test plan
- A read, addr 0x012345, with the controller model returning 0xBEEF → `a_ready` ×1, `sd_rd_enable` held until `sd_busy`, `a_rvalid` ×1 with `a_rdata` = 0xBEEF.
- `a_valid` and `b_valid` rise together, B read → A granted first; B granted on the next IDLE cycle; responses arrive in that order.
- A held valid continuously, B valid, `A_MAX_STREAK` = 4 → grant sequence A, A, A, A, B, A…; streak returns to 0 after the B grant.
- B writes 0x5A5A to 0x00FF00, then reads 0x00FF00 → `b_wdone` ×1, then `b_rvalid` with 0x5A5A; `sd_wr_enable` and `sd_rd_enable` never high together.
- Request issued during controller init and during a refresh window (`sd_busy` = 0 for 20 cycles) → enable held and stable the whole time; completes normally afterward.
- `rst_n` low in WAIT (read pending) → all outputs 0 immediately (asynchronous); no rvalid; after release, a new A read completes correctly.
